mem_bus_arbiter: RTL and testbench

Shares the single external memory bus between the CPU load/store/fetch path and a secondary DMA/debug requester. It sequences each bus cycle through grant, strobe, wait-state and acknowledge phases. It inserts programmable wait states and honours a memory ready line, with a timeout. It sits between the control multiplexer's address/data bus selections and the memory interface, and drives a stall line that holds the instruction phase decoder while a CPU access is outstanding.

---
 rtl/mem_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the external memory bus between the CPU path and a secondary
//   DMA/debug requester. Each bus cycle runs IDLE -> ACCESS -> DONE:
//   grant and latch the request in IDLE, drive strobes in ACCESS while
//   programmable wait states elapse and MEM_READY (or a timeout) ends the
//   access, then pulse the owner's ACK in DONE.
//
// Parameters
//   WAIT_STATES  ACCESS cycles during which mem_ready is ignored (0..15)
//   TIMEOUT      ACCESS cycles after the wait states without mem_ready
//                before the cycle is aborted with bus_err (1..255)
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   cpu_req/cpu_wr/cpu_addr/cpu_dout   CPU request, write flag, addr, data
//   cpu_ack, cpu_din, cpu_stall        CPU completion pulse, read data, stall
//   dma_req/dma_wr/dma_addr/dma_dout   DMA request, write flag, addr, data
//   dma_ack, dma_din, dma_gnt          DMA completion pulse, read data, owner
//   bus_err                     pulses with ACK when the access timed out
//   mem_addr, mem_dout          registered address / write data
//   mem_rd, mem_wr              strobes, high only during ACCESS
//   mem_din, mem_ready          memory read data and ready
module mem_bus_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMEOUT     = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_dout,
  output logic        cpu_ack,
  output logic [15:0] cpu_din,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_dout,
  output logic        dma_ack,
  output logic [15:0] dma_din,
  output logic        dma_gnt,
  output logic        bus_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_dout,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_din,
  input  logic        mem_ready
);

  localparam logic [3:0] WS_INIT = WAIT_STATES[3:0];
  localparam logic [7:0] TO_INIT = TIMEOUT[7:0];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        owner_dma;   // 1: current/last cycle belongs to DMA
  logic        wr_q;        // write flag frozen at grant
  logic        err_q;       // current cycle timed out
  logic        last_dma;    // round-robin: DMA was served last
  logic [3:0]  wait_cnt;
  logic [7:0]  to_cnt;

  logic        req_any;
  logic        grant_dma;
  logic        wait_zero;
  logic        to_zero;

  assign req_any   = cpu_req | dma_req;
  // On a tie the port not served last wins.
  assign grant_dma = dma_req & ~(cpu_req & last_dma);
  assign wait_zero = (wait_cnt == '0);
  assign to_zero   = (to_cnt == '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode. Outputs depend on state only, so an
  // asynchronous reset drops the strobes immediately.
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    dma_gnt   = 1'b0;
    bus_err   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req_any) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_rd  = ~wr_q;
        mem_wr  = wr_q;
        dma_gnt = owner_dma;
        if (wait_zero && (mem_ready || to_zero)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        cpu_ack   = ~owner_dma;
        dma_ack   = owner_dma;
        dma_gnt   = owner_dma;
        bus_err   = err_q;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_ack;

  // Request latch, counters and read-data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_dma <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      last_dma  <= 1'b1;
      wait_cnt  <= '0;
      to_cnt    <= '0;
      mem_addr  <= '0;
      mem_dout  <= '0;
      cpu_din   <= '0;
      dma_din   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_any) begin
            owner_dma <= grant_dma;
            wr_q      <= grant_dma ? dma_wr   : cpu_wr;
            mem_addr  <= grant_dma ? dma_addr : cpu_addr;
            mem_dout  <= grant_dma ? dma_dout : cpu_dout;
            wait_cnt  <= WS_INIT;
            to_cnt    <= TO_INIT;
            err_q     <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (!wait_zero) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (mem_ready) begin
            if (!wr_q) begin
              if (owner_dma) begin
                dma_din <= mem_din;
              end else begin
                cpu_din <= mem_din;
              end
            end
          end else if (to_zero) begin
            err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt - 8'd1;
          end
        end
        ST_DONE: begin
          last_dma <= owner_dma;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. Two instances with different
// wait-state/timeout settings share one stimulus stream; a transaction-level
// model per instance predicts every output on every cycle.
module tb_mem_bus_arbiter;

  localparam int unsigned WS0 = 1;
  localparam int unsigned TO0 = 3;
  localparam int unsigned WS1 = 0;
  localparam int unsigned TO1 = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_dout = '0;
  logic        dma_req = 1'b0, dma_wr = 1'b0;
  logic [15:0] dma_addr = '0, dma_dout = '0;
  logic [15:0] mem_din = '0;
  logic        mem_ready = 1'b0;

  logic [1:0]  cpu_ack_v, cpu_stall_v, dma_ack_v, dma_gnt_v, bus_err_v;
  logic [1:0]  mem_rd_v, mem_wr_v;
  logic [15:0] cpu_din_v [2];
  logic [15:0] dma_din_v [2];
  logic [15:0] mem_addr_v [2];
  logic [15:0] mem_dout_v [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.WAIT_STATES(WS0), .TIMEOUT(TO0)) dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_ack(cpu_ack_v[0]), .cpu_din(cpu_din_v[0]), .cpu_stall(cpu_stall_v[0]),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_dout(dma_dout),
    .dma_ack(dma_ack_v[0]), .dma_din(dma_din_v[0]), .dma_gnt(dma_gnt_v[0]),
    .bus_err(bus_err_v[0]), .mem_addr(mem_addr_v[0]), .mem_dout(mem_dout_v[0]),
    .mem_rd(mem_rd_v[0]), .mem_wr(mem_wr_v[0]), .mem_din(mem_din), .mem_ready(mem_ready)
  );

  mem_bus_arbiter #(.WAIT_STATES(WS1), .TIMEOUT(TO1)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_ack(cpu_ack_v[1]), .cpu_din(cpu_din_v[1]), .cpu_stall(cpu_stall_v[1]),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_dout(dma_dout),
    .dma_ack(dma_ack_v[1]), .dma_din(dma_din_v[1]), .dma_gnt(dma_gnt_v[1]),
    .bus_err(bus_err_v[1]), .mem_addr(mem_addr_v[1]), .mem_dout(mem_dout_v[1]),
    .mem_rd(mem_rd_v[1]), .mem_wr(mem_wr_v[1]), .mem_din(mem_din), .mem_ready(mem_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 access, 2 done. cyc counts ACCESS cycles from 1.
  int          ws_of [2] = '{WS0, WS1};
  int          to_of [2] = '{TO0, TO1};
  int          m_phase [2] = '{0, 0};
  int          m_cyc [2] = '{0, 0};
  bit          m_own [2] = '{0, 0};
  bit          m_wr [2] = '{0, 0};
  bit          m_err [2] = '{0, 0};
  bit          m_last [2] = '{1, 1};
  logic [15:0] m_addr [2] = '{16'h0, 16'h0};
  logic [15:0] m_dout [2] = '{16'h0, 16'h0};
  logic [15:0] m_cdin [2] = '{16'h0, 16'h0};
  logic [15:0] m_ddin [2] = '{16'h0, 16'h0};

  function automatic bit pick_dma(input bit last);
    return dma_req && !(cpu_req && last);
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_phase[i] <= 0;  m_cyc[i] <= 0;  m_own[i] <= 0;  m_wr[i] <= 0;
        m_err[i] <= 0;    m_last[i] <= 1;
        m_addr[i] <= '0;  m_dout[i] <= '0; m_cdin[i] <= '0; m_ddin[i] <= '0;
      end else begin
        case (m_phase[i])
          0: if (cpu_req || dma_req) begin
            m_own[i]   <= pick_dma(m_last[i]);
            m_wr[i]    <= pick_dma(m_last[i]) ? dma_wr   : cpu_wr;
            m_addr[i]  <= pick_dma(m_last[i]) ? dma_addr : cpu_addr;
            m_dout[i]  <= pick_dma(m_last[i]) ? dma_dout : cpu_dout;
            m_err[i]   <= 0;
            m_cyc[i]   <= 1;
            m_phase[i] <= 1;
          end
          1: if (m_cyc[i] > ws_of[i] && mem_ready) begin
            if (!m_wr[i]) begin
              if (m_own[i]) m_ddin[i] <= mem_din;
              else          m_cdin[i] <= mem_din;
            end
            m_phase[i] <= 2;
          end else if (m_cyc[i] == ws_of[i] + to_of[i] + 1) begin
            m_err[i]   <= 1;
            m_phase[i] <= 2;
          end else begin
            m_cyc[i] <= m_cyc[i] + 1;
          end
          default: begin
            m_last[i]  <= m_own[i];
            m_phase[i] <= 0;
          end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mem_rd%0d", i),   32'(mem_rd_v[i]),  32'(m_phase[i] == 1 && !m_wr[i]));
      chk($sformatf("mem_wr%0d", i),   32'(mem_wr_v[i]),  32'(m_phase[i] == 1 && m_wr[i]));
      chk($sformatf("cpu_ack%0d", i),  32'(cpu_ack_v[i]), 32'(m_phase[i] == 2 && !m_own[i]));
      chk($sformatf("dma_ack%0d", i),  32'(dma_ack_v[i]), 32'(m_phase[i] == 2 && m_own[i]));
      chk($sformatf("dma_gnt%0d", i),  32'(dma_gnt_v[i]), 32'(m_phase[i] != 0 && m_own[i]));
      chk($sformatf("bus_err%0d", i),  32'(bus_err_v[i]), 32'(m_phase[i] == 2 && m_err[i]));
      chk($sformatf("cpu_stall%0d", i), 32'(cpu_stall_v[i]),
          32'(cpu_req && !(m_phase[i] == 2 && !m_own[i])));
      chk($sformatf("mem_addr%0d", i), 32'(mem_addr_v[i]), 32'(m_addr[i]));
      chk($sformatf("mem_dout%0d", i), 32'(mem_dout_v[i]), 32'(m_dout[i]));
      chk($sformatf("cpu_din%0d", i),  32'(cpu_din_v[i]),  32'(m_cdin[i]));
      chk($sformatf("dma_din%0d", i),  32'(dma_din_v[i]),  32'(m_ddin[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One transaction observed on dut0. mem_ready rises so that it is first
  // sampled (after the wait states) 'extra' cycles late.
  task automatic run_txn(input string nm, input bit dma, input bit wr,
                         input logic [15:0] addr, input logic [15:0] dout,
                         input logic [15:0] din, input int extra,
                         input int exp_strobe, input bit exp_err);
    int n = 0, acks = 0, oacks = 0, post = 0;
    bit seen = 0, err_at = 0, gnt_at = 0, addr_ok = 1;
    if (dma) begin
      dma_req = 1; dma_wr = wr; dma_addr = addr; dma_dout = dout;
    end else begin
      cpu_req = 1; cpu_wr = wr; cpu_addr = addr; cpu_dout = dout;
    end
    mem_din = din;
    mem_ready = 0;
    for (int t = 0; t < 40 && post < 3; t++) begin
      tick();
      if (seen) post++;
      if (mem_rd_v[0] || mem_wr_v[0]) begin
        n++;
        if (mem_addr_v[0] !== addr) addr_ok = 0;
      end
      mem_ready = (n >= int'(WS0) + 1 + extra);
      if (dma ? dma_ack_v[0] : cpu_ack_v[0]) begin
        acks++;
        err_at = bus_err_v[0];
        gnt_at = dma_gnt_v[0];
        seen = 1;
        cpu_req = 0;
        dma_req = 0;
        mem_ready = 0;
      end
      if (dma ? cpu_ack_v[0] : dma_ack_v[0]) oacks++;
    end
    chk({nm, "_strobe_cycles"}, n, exp_strobe);
    chk({nm, "_ack_count"}, acks, 1);
    chk({nm, "_other_ack"}, oacks, 0);
    chk({nm, "_bus_err"}, 32'(err_at), 32'(exp_err));
    chk({nm, "_mem_addr"}, 32'(addr_ok), 1);
    if (dma) chk({nm, "_gnt_in_done"}, 32'(gnt_at), 1);
  endtask

  initial begin
    int acks;
    int ready_pct;
    bit prev_strobe;
    int order [$];

    // reset values
    do_reset();
    chk("rst_mem_addr", 32'(mem_addr_v[0]), 0);
    chk("rst_cpu_din", 32'(cpu_din_v[0]), 0);
    chk("rst_strobes", 32'({mem_rd_v[0], mem_wr_v[0]}), 0);
    chk("rst_acks", 32'({cpu_ack_v[0], dma_ack_v[0], dma_gnt_v[0], bus_err_v[0]}), 0);

    // reset during ACCESS drops the strobe without a clock edge, no ACK
    cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h5555; mem_ready = 0;
    tick();
    chk("pre_reset_mem_rd", 32'(mem_rd_v[0]), 1);
    #2 reset = 1; cpu_req = 0;
    #1 chk("async_reset_mem_rd", 32'(mem_rd_v[0]), 0);
    acks = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      reset = 0;
      acks += int'(cpu_ack_v[0]) + int'(dma_ack_v[0]);
    end
    chk("no_ack_after_reset", acks, 0);

    // CPU read, 2 strobe cycles at WAIT_STATES=1
    run_txn("cpu_read", 0, 0, 16'h1234, 16'h0000, 16'hBEEF, 0, 2, 0);
    chk("cpu_read_din", 32'(cpu_din_v[0]), 32'h0000BEEF);

    // DMA write, ready 3 cycles late -> 1+1+3 strobe cycles
    run_txn("dma_write", 1, 1, 16'h0040, 16'h00A5, 16'hDEAD, 3, 5, 0);
    chk("dma_write_cpu_din_kept", 32'(cpu_din_v[0]), 32'h0000BEEF);

    // timeout: WAIT_STATES + TIMEOUT + 1 = 5 ACCESS cycles, DIN unchanged
    run_txn("timeout", 0, 0, 16'h0777, 16'h0000, 16'h4242, 99, 5, 1);
    chk("timeout_din_kept", 32'(cpu_din_v[0]), 32'h0000BEEF);

    // address change and REQ withdrawal mid-ACCESS
    cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h2222; mem_ready = 0;
    tick();
    tick();
    cpu_addr = 16'h9999;
    cpu_req = 0;
    tick();
    chk("frozen_addr", 32'(mem_addr_v[0]), 32'h00002222);
    mem_ready = 1;
    acks = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      acks += int'(cpu_ack_v[0]);
    end
    chk("withdrawn_ack_count", acks, 1);
    chk("withdrawn_addr", 32'(mem_addr_v[0]), 32'h00002222);

    // round-robin from reset with both requesters held high
    do_reset();
    cpu_req = 1; dma_req = 1; cpu_wr = 0; dma_wr = 0; mem_ready = 1;
    prev_strobe = 0;
    for (int t = 0; t < 60 && order.size() < 4; t++) begin
      tick();
      if ((mem_rd_v[0] || mem_wr_v[0]) && !prev_strobe) order.push_back(int'(dma_gnt_v[0]));
      prev_strobe = mem_rd_v[0] || mem_wr_v[0];
    end
    cpu_req = 0; dma_req = 0;
    chk("rr_grant_count", order.size(), 4);
    for (int k = 0; k < order.size(); k++) begin
      chk($sformatf("rr_grant%0d_is_dma", k), order[k], k % 2);
    end
    for (int t = 0; t < 8; t++) tick();

    // randomized traffic, model-checked every cycle
    ready_pct = 90;
    for (int t = 0; t < 3000; t++) begin
      if (t % 64 == 0) ready_pct = ($urandom_range(0, 1) == 0) ? 15 : 90;
      cpu_req   = ($urandom_range(0, 99) < 45);
      dma_req   = ($urandom_range(0, 99) < 35);
      cpu_wr    = 1'($urandom);
      dma_wr    = 1'($urandom);
      cpu_addr  = 16'($urandom);
      cpu_dout  = 16'($urandom);
      dma_addr  = 16'($urandom);
      dma_dout  = 16'($urandom);
      mem_din   = 16'($urandom);
      mem_ready = ($urandom_range(0, 99) < ready_pct);
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0; cpu_req = 0; dma_req = 0; mem_ready = 1;
    for (int t = 0; t < 20; t++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
